video_out: RTL and testbench

Parametrised VGA output stage that replaces the fixed 4-bit colour/sync register in the display top level. It delays the timing signals (hsync, vsync, active) by a configurable number of cycles to match fragment-pipeline latency, applies colour-depth conversion, blanks outside the active region and applies programmable sync polarity. It also provides a frame-start pulse and a frame counter for downstream animation logic.

---
 rtl/video_out.sv | 138 +++++++++++++
 tb/tb_video_out.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_out.sv
// VGA output stage: delays sync/active timing to line up with the fragment pipeline,
// converts colour depth, blanks, applies sync polarity and counts frames.
// Optional test-pattern generator is built when VIDEO_TEST_PATTERN_EN is defined.
module video_out #(
  parameter int   IN_BITS    = 4,
  parameter int   OUT_BITS   = 4,
  parameter int   SYNC_DELAY = 2,
  parameter logic HSYNC_POL  = 1'b0,
  parameter logic VSYNC_POL  = 1'b0,
  parameter int   FRAME_BITS = 16,
  parameter int   BAR_W      = 80
) (
  input  logic                  clk_pix,
  input  logic                  rst,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  input  logic                  active_in,
  input  logic [IN_BITS-1:0]    r_in,
  input  logic [IN_BITS-1:0]    g_in,
  input  logic [IN_BITS-1:0]    b_in,
  input  logic                  test_en,
  output logic [OUT_BITS-1:0]   vga_r,
  output logic [OUT_BITS-1:0]   vga_g,
  output logic [OUT_BITS-1:0]   vga_b,
  output logic                  vga_hsync,
  output logic                  vga_vsync,
  output logic                  frame_start,
  output logic [FRAME_BITS-1:0] frame_count
);

  // Output bit k takes input bits MSB-first, cycling through the input as often as
  // needed; this covers pass-through, truncation and bit replication in one rule.
  function automatic logic [OUT_BITS-1:0] convert_colour(input logic [IN_BITS-1:0] c);
    logic [OUT_BITS-1:0] o;
    o = '0;
    for (int i = 0; i < OUT_BITS; i++) begin
      o[OUT_BITS-1-i] = c[IN_BITS-1-(i % IN_BITS)];
    end
    return o;
  endfunction

  logic hs_d;
  logic vs_d;
  logic act_d;

  // Stage p0: timing delay line
  generate
    if (SYNC_DELAY == 0) begin : g_nodly
      assign {hs_d, vs_d, act_d} = {hsync_in, vsync_in, active_in};
    end else begin : g_dly
      logic [2:0] dly_p0 [SYNC_DELAY];

      always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < SYNC_DELAY; i++) dly_p0[i] <= 3'b000;
        end else begin
          dly_p0[0] <= {hsync_in, vsync_in, active_in};
          for (int i = 1; i < SYNC_DELAY; i++) dly_p0[i] <= dly_p0[i-1];
        end
      end

      assign {hs_d, vs_d, act_d} = dly_p0[SYNC_DELAY-1];
    end
  endgenerate

  logic [OUT_BITS-1:0] r_sel;
  logic [OUT_BITS-1:0] g_sel;
  logic [OUT_BITS-1:0] b_sel;

`ifdef VIDEO_TEST_PATTERN_EN
  localparam int COL_W = $clog2(BAR_W + 1);

  logic [COL_W-1:0] col_p0;
  logic [2:0]       bar_p0;

  // Position within the current bar, restarting at each blanking interval
  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      col_p0 <= '0;
      bar_p0 <= 3'd0;
    end else if (!act_d) begin
      col_p0 <= '0;
      bar_p0 <= 3'd0;
    end else if (col_p0 == COL_W'(BAR_W - 1)) begin
      col_p0 <= '0;
      bar_p0 <= bar_p0 + 3'd1;
    end else begin
      col_p0 <= col_p0 + COL_W'(1);
    end
  end

  always_comb begin
    r_sel = convert_colour(r_in);
    g_sel = convert_colour(g_in);
    b_sel = convert_colour(b_in);
    if (test_en) begin
      r_sel = {OUT_BITS{bar_p0[2]}};
      g_sel = {OUT_BITS{bar_p0[1]}};
      b_sel = {OUT_BITS{bar_p0[0]}};
    end
  end
`else
  logic unused_test_en;
  assign unused_test_en = test_en;

  always_comb begin
    r_sel = convert_colour(r_in);
    g_sel = convert_colour(g_in);
    b_sel = convert_colour(b_in);
  end
`endif

  logic vs_prev_p1;

  // Stage p1: output register, blanking, sync polarity and frame detection
  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hsync   <= ~HSYNC_POL;
      vga_vsync   <= ~VSYNC_POL;
      vs_prev_p1  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      vga_r       <= act_d ? r_sel : '0;
      vga_g       <= act_d ? g_sel : '0;
      vga_b       <= act_d ? b_sel : '0;
      vga_hsync   <= hs_d ? HSYNC_POL : ~HSYNC_POL;
      vga_vsync   <= vs_d ? VSYNC_POL : ~VSYNC_POL;
      vs_prev_p1  <= vs_d;
      frame_start <= vs_d & ~vs_prev_p1;
      if (vs_d && !vs_prev_p1) frame_count <= frame_count + FRAME_BITS'(1);
    end
  end

endmodule

// File: tb/tb_video_out.sv
// Scoreboard bench for video_out: four instances cover default, widening with
// positive syncs and zero delay, narrowing, and 3-to-8 replication.
module tb_video_out;

  localparam int MAXN = 720;

  logic clk_pix = 1'b0;
  logic rst = 1'b0;
  logic hsync_in = 1'b0, vsync_in = 1'b0, active_in = 1'b0, test_en = 1'b0;
  logic [3:0] r4 = '0, g4 = '0, b4 = '0;
  logic [7:0] r8 = '0;
  logic [2:0] r3 = '0;

  logic [3:0]  m_r, m_g, m_b;
  logic        m_hs, m_vs, m_fs;
  logic [15:0] m_fc;
  logic [7:0]  w_r, w_g_unused, w_b_unused;
  logic        w_hs, w_vs, w_fs;
  logic [1:0]  w_fc;
  logic [3:0]  n_r, n_g_unused, n_b_unused;
  logic        n_hs_unused, n_vs_unused, n_fs_unused;
  logic [15:0] n_fc_unused;
  logic [7:0]  o_r, o_g_unused, o_b_unused;
  logic        o_hs_unused, o_vs_unused, o_fs_unused;
  logic [15:0] o_fc_unused;

  int checks = 0;
  int failures = 0;

  always #5 clk_pix = ~clk_pix;

  video_out u_main (
    .clk_pix(clk_pix), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .active_in(active_in), .r_in(r4), .g_in(g4), .b_in(b4), .test_en(test_en),
    .vga_r(m_r), .vga_g(m_g), .vga_b(m_b), .vga_hsync(m_hs), .vga_vsync(m_vs),
    .frame_start(m_fs), .frame_count(m_fc)
  );

  video_out #(.IN_BITS(4), .OUT_BITS(8), .SYNC_DELAY(0), .HSYNC_POL(1'b1),
              .VSYNC_POL(1'b1), .FRAME_BITS(2)) u_wide (
    .clk_pix(clk_pix), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .active_in(active_in), .r_in(r4), .g_in(g4), .b_in(b4), .test_en(test_en),
    .vga_r(w_r), .vga_g(w_g_unused), .vga_b(w_b_unused), .vga_hsync(w_hs),
    .vga_vsync(w_vs), .frame_start(w_fs), .frame_count(w_fc)
  );

  video_out #(.IN_BITS(8), .OUT_BITS(4)) u_narrow (
    .clk_pix(clk_pix), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .active_in(active_in), .r_in(r8), .g_in(r8), .b_in(r8), .test_en(test_en),
    .vga_r(n_r), .vga_g(n_g_unused), .vga_b(n_b_unused), .vga_hsync(n_hs_unused),
    .vga_vsync(n_vs_unused), .frame_start(n_fs_unused), .frame_count(n_fc_unused)
  );

  video_out #(.IN_BITS(3), .OUT_BITS(8)) u_odd (
    .clk_pix(clk_pix), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .active_in(active_in), .r_in(r3), .g_in(r3), .b_in(r3), .test_en(test_en),
    .vga_r(o_r), .vga_g(o_g_unused), .vga_b(o_b_unused), .vga_hsync(o_hs_unused),
    .vga_vsync(o_vs_unused), .frame_start(o_fs_unused), .frame_count(o_fc_unused)
  );

  // Stimulus tables, one entry per clock
  logic       hs_s  [MAXN];
  logic       vs_s  [MAXN];
  logic       act_s [MAXN];
  logic       te_s  [MAXN];
  logic [3:0] r4_s  [MAXN];
  logic [3:0] g4_s  [MAXN];
  logic [3:0] b4_s  [MAXN];
  logic [7:0] r8_s  [MAXN];
  logic [2:0] r3_s  [MAXN];

  typedef struct {
    logic [3:0]  r, g, b;
    logic        hs, vs, fs;
    logic [15:0] fc;
    logic [7:0]  wr;
    logic        wh, wv, wfs;
    logic [1:0]  wfc;
    logic [3:0]  nr;
    logic [7:0]  orr;
  } exp_t;

  exp_t exp_q[$];

  function automatic logic get_act(input int i);
    return (i < 0) ? 1'b0 : act_s[i];
  endfunction
  function automatic logic get_hs(input int i);
    return (i < 0) ? 1'b0 : hs_s[i];
  endfunction
  function automatic logic get_vs(input int i);
    return (i < 0) ? 1'b0 : vs_s[i];
  endfunction

  task automatic clear_stim(input int n);
    for (int j = 0; j < n; j++) begin
      hs_s[j] = 0; vs_s[j] = 0; act_s[j] = 0; te_s[j] = 0;
      r4_s[j] = 0; g4_s[j] = 0; b4_s[j] = 0; r8_s[j] = 0; r3_s[j] = 0;
    end
  endtask

  task automatic rand_colour(input int n);
    for (int j = 0; j < n; j++) begin
      r4_s[j] = 4'($urandom); g4_s[j] = 4'($urandom); b4_s[j] = 4'($urandom);
      r8_s[j] = 8'($urandom); r3_s[j] = 3'($urandom);
    end
  endtask

  // Expected pins after edge j, assuming everything before index 0 is idle (fresh reset).
  // Main/narrow/odd see timing from index j-2, the wide instance from index j.
  task automatic load_expected(input int n);
    exp_t e;
    int t;
    logic a;
    logic [15:0] fc;
    logic [1:0] wfc;
`ifdef VIDEO_TEST_PATTERN_EN
    int run, col;
    logic [2:0] bar;
    run = 0;
`endif
    exp_q.delete();
    fc = '0;
    wfc = '0;
    for (int j = 0; j < n; j++) begin
      t = j - 2;
      a = get_act(t);
      e.r = a ? r4_s[j] : 4'h0;
      e.g = a ? g4_s[j] : 4'h0;
      e.b = a ? b4_s[j] : 4'h0;
`ifdef VIDEO_TEST_PATTERN_EN
      col = run;
      run = a ? run + 1 : 0;
      bar = 3'((col / 80) % 8);
      if (a && te_s[j]) begin
        e.r = {4{bar[2]}}; e.g = {4{bar[1]}}; e.b = {4{bar[0]}};
      end
`endif
      e.hs = ~get_hs(t);
      e.vs = ~get_vs(t);
      e.fs = get_vs(t) & ~get_vs(t - 1);
      fc = fc + 16'(e.fs);
      e.fc = fc;
      e.wh = get_hs(j);
      e.wv = get_vs(j);
      e.wfs = get_vs(j) & ~get_vs(j - 1);
      wfc = wfc + 2'(e.wfs);
      e.wfc = wfc;
      e.wr = get_act(j) ? {r4_s[j], r4_s[j]} : 8'h00;
      e.nr = a ? r8_s[j][7:4] : 4'h0;
      e.orr = a ? {r3_s[j], r3_s[j], r3_s[j][2:1]} : 8'h00;
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_cycle(input int j);
    hsync_in = hs_s[j]; vsync_in = vs_s[j]; active_in = act_s[j]; test_en = te_s[j];
    r4 = r4_s[j]; g4 = g4_s[j]; b4 = b4_s[j]; r8 = r8_s[j]; r3 = r3_s[j];
    @(posedge clk_pix);
    #1;
  endtask

  task automatic do_reset;
    hsync_in = 0; vsync_in = 0; active_in = 0; test_en = 0;
    rst = 1'b1;
    @(posedge clk_pix);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    #1;
    checks++; if (m_hs !== 1'b1) begin failures++; $display("FAIL rst_async_hs got=%b exp=1", m_hs); end
    checks++; if (m_vs !== 1'b1) begin failures++; $display("FAIL rst_async_vs got=%b exp=1", m_vs); end
    checks++; if (m_r !== 4'h0) begin failures++; $display("FAIL rst_async_r got=%h exp=0", m_r); end
    checks++; if (w_hs !== 1'b0) begin failures++; $display("FAIL rst_async_whs got=%b exp=0", w_hs); end
    for (int k = 0; k < 3; k++) begin
      hsync_in = 1'($urandom); vsync_in = 1'($urandom); active_in = 1'b1;
      r4 = 4'($urandom); g4 = 4'($urandom); b4 = 4'($urandom);
      @(posedge clk_pix);
      #1;
      checks++; if ({m_r, m_g, m_b} !== 12'h000) begin failures++; $display("FAIL rst_rgb k=%0d got=%h exp=000", k, {m_r, m_g, m_b}); end
      checks++; if ({m_hs, m_vs} !== 2'b11) begin failures++; $display("FAIL rst_sync k=%0d got=%b exp=11", k, {m_hs, m_vs}); end
      checks++; if (m_fc !== 16'd0 || m_fs !== 1'b0) begin failures++; $display("FAIL rst_frame k=%0d got=%0d/%b exp=0/0", k, m_fc, m_fs); end
      checks++; if ({w_hs, w_vs} !== 2'b00 || w_r !== 8'h00) begin failures++; $display("FAIL rst_wide k=%0d got=%b/%h exp=00/00", k, {w_hs, w_vs}, w_r); end
    end
    rst = 1'b0;
  endtask

  task automatic test_latency;
    exp_t e;
    int hits, pos;
    clear_stim(20);
    rand_colour(20);
    for (int j = 0; j < 20; j++) r4_s[j] = 4'h0;
    act_s[10] = 1'b1;
    r4_s[12] = 4'hF;
    load_expected(20);
    do_reset();
    hits = 0; pos = -1;
    for (int j = 0; j < 20; j++) begin
      drive_cycle(j);
      e = exp_q.pop_front();
      if (m_r == 4'hF) begin hits++; pos = j; end
      checks++; if ({m_r, m_g, m_b} !== {e.r, e.g, e.b}) begin failures++; $display("FAIL lat_rgb j=%0d got=%h exp=%h", j, {m_r, m_g, m_b}, {e.r, e.g, e.b}); end
    end
    checks++; if (hits !== 1 || pos !== 12) begin failures++; $display("FAIL lat_pulse got=%0d@%0d exp=1@12", hits, pos); end
  endtask

  task automatic test_conversion;
    exp_t e;
    clear_stim(16);
    rand_colour(16);
    for (int j = 0; j < 16; j++) act_s[j] = 1'b1;
    for (int j = 0; j < 8; j++) begin r4_s[j] = 4'hA; r8_s[j] = 8'h9C; r3_s[j] = 3'b101; end
    load_expected(16);
    do_reset();
    for (int j = 0; j < 16; j++) begin
      drive_cycle(j);
      e = exp_q.pop_front();
      checks++; if (w_r !== e.wr) begin failures++; $display("FAIL conv_4to8 j=%0d got=%h exp=%h", j, w_r, e.wr); end
      checks++; if (n_r !== e.nr) begin failures++; $display("FAIL conv_8to4 j=%0d got=%h exp=%h", j, n_r, e.nr); end
      checks++; if (o_r !== e.orr) begin failures++; $display("FAIL conv_3to8 j=%0d got=%h exp=%h", j, o_r, e.orr); end
      if (j == 4) begin
        checks++; if ({w_r, n_r, o_r} !== {8'hAA, 4'h9, 8'hB6}) begin failures++; $display("FAIL conv_const got=%h/%h/%h exp=aa/9/b6", w_r, n_r, o_r); end
      end
    end
  endtask

  task automatic test_polarity;
    exp_t e;
    int whigh, mlow;
    clear_stim(110);
    rand_colour(110);
    for (int j = 5; j < 101; j++) hs_s[j] = 1'b1;
    load_expected(110);
    do_reset();
    whigh = 0; mlow = 0;
    for (int j = 0; j < 110; j++) begin
      drive_cycle(j);
      e = exp_q.pop_front();
      whigh += int'(w_hs === 1'b1);
      mlow += int'(m_hs === 1'b0);
      checks++; if (m_hs !== e.hs) begin failures++; $display("FAIL pol_main j=%0d got=%b exp=%b", j, m_hs, e.hs); end
      checks++; if (w_hs !== e.wh) begin failures++; $display("FAIL pol_wide j=%0d got=%b exp=%b", j, w_hs, e.wh); end
    end
    checks++; if (whigh !== 96 || mlow !== 96) begin failures++; $display("FAIL pol_len got=%0d/%0d exp=96/96", whigh, mlow); end
  endtask

  task automatic test_frames;
    exp_t e;
    int seq[$];
    int exp_seq[5] = '{1, 2, 3, 0, 1};
    clear_stim(60);
    rand_colour(60);
    for (int p = 0; p < 4; p++)
      for (int j = 3 + 10 * p; j < 7 + 10 * p; j++) vs_s[j] = 1'b1;
    for (int j = 43; j < 60; j++) vs_s[j] = 1'b1;
    load_expected(60);
    do_reset();
    for (int j = 0; j < 60; j++) begin
      drive_cycle(j);
      e = exp_q.pop_front();
      if (w_fs === 1'b1) seq.push_back(int'(w_fc));
      checks++; if ({m_vs, m_fs, m_fc} !== {e.vs, e.fs, e.fc}) begin failures++; $display("FAIL frm_main j=%0d got=%b/%b/%0d exp=%b/%b/%0d", j, m_vs, m_fs, m_fc, e.vs, e.fs, e.fc); end
      checks++; if ({w_vs, w_fs, w_fc} !== {e.wv, e.wfs, e.wfc}) begin failures++; $display("FAIL frm_wide j=%0d got=%b/%b/%0d exp=%b/%b/%0d", j, w_vs, w_fs, w_fc, e.wv, e.wfs, e.wfc); end
    end
    checks++; if (seq.size() !== 5) begin failures++; $display("FAIL frm_count got=%0d exp=5", seq.size()); end
    for (int k = 0; k < 5 && k < seq.size(); k++) begin
      checks++; if (seq[k] !== exp_seq[k]) begin failures++; $display("FAIL frm_seq k=%0d got=%0d exp=%0d", k, seq[k], exp_seq[k]); end
    end
  endtask

  task automatic test_midline_reset;
    exp_t e;
    clear_stim(30);
    rand_colour(30);
    for (int j = 2; j < 30; j++) begin act_s[j] = 1'b1; hs_s[j] = (j > 9); end
    for (int j = 8; j < 30; j++) vs_s[j] = 1'b1;
    load_expected(30);
    do_reset();
    for (int j = 0; j < 15; j++) begin
      drive_cycle(j);
      e = exp_q.pop_front();
      checks++; if ({m_r, m_hs, m_vs, m_fc} !== {e.r, e.hs, e.vs, e.fc}) begin failures++; $display("FAIL mid_pre j=%0d got=%h/%b/%b/%0d exp=%h/%b/%b/%0d", j, m_r, m_hs, m_vs, m_fc, e.r, e.hs, e.vs, e.fc); end
    end
    #2 rst = 1'b1;
    #1;
    checks++; if ({m_r, m_g, m_b} !== 12'h000 || {m_hs, m_vs} !== 2'b11) begin failures++; $display("FAIL mid_idle got=%h/%b exp=000/11", {m_r, m_g, m_b}, {m_hs, m_vs}); end
    checks++; if (m_fc !== 16'd0 || w_fc !== 2'd0) begin failures++; $display("FAIL mid_fc got=%0d/%0d exp=0/0", m_fc, w_fc); end
    @(posedge clk_pix);
    #1 rst = 1'b0;
    clear_stim(12);
    rand_colour(12);
    for (int j = 0; j < 12; j++) begin act_s[j] = 1'b1; vs_s[j] = 1'b1; end
    load_expected(12);
    for (int j = 0; j < 12; j++) begin
      drive_cycle(j);
      e = exp_q.pop_front();
      checks++; if ({m_r, m_vs, m_fs, m_fc} !== {e.r, e.vs, e.fs, e.fc}) begin failures++; $display("FAIL mid_post j=%0d got=%h/%b/%b/%0d exp=%h/%b/%b/%0d", j, m_r, m_vs, m_fs, m_fc, e.r, e.vs, e.fs, e.fc); end
    end
  endtask

  task automatic test_pattern;
    exp_t e;
    clear_stim(700);
    rand_colour(700);
    for (int j = 0; j < 700; j++) begin
      te_s[j] = 1'b1;
      act_s[j] = (j >= 20 && j < 660);
    end
    load_expected(700);
    do_reset();
    for (int j = 0; j < 700; j++) begin
      drive_cycle(j);
      e = exp_q.pop_front();
      checks++; if ({m_r, m_g, m_b} !== {e.r, e.g, e.b}) begin failures++; $display("FAIL pat_rgb j=%0d got=%h exp=%h", j, {m_r, m_g, m_b}, {e.r, e.g, e.b}); end
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    clear_stim(300);
    rand_colour(300);
    for (int j = 0; j < 300; j++) begin
      act_s[j] = ($urandom_range(0, 3) != 0);
      hs_s[j] = ($urandom_range(0, 4) == 0);
      vs_s[j] = ($urandom_range(0, 2) == 0);
    end
    load_expected(300);
    do_reset();
    for (int j = 0; j < 300; j++) begin
      drive_cycle(j);
      e = exp_q.pop_front();
      checks++; if ({m_r, m_g, m_b, m_hs, m_vs, m_fs, m_fc} !== {e.r, e.g, e.b, e.hs, e.vs, e.fs, e.fc}) begin failures++; $display("FAIL b2b_main j=%0d got=%h/%b%b%b/%0d exp=%h/%b%b%b/%0d", j, {m_r, m_g, m_b}, m_hs, m_vs, m_fs, m_fc, {e.r, e.g, e.b}, e.hs, e.vs, e.fs, e.fc); end
      checks++; if ({w_r, w_hs, w_vs, w_fs, w_fc} !== {e.wr, e.wh, e.wv, e.wfs, e.wfc}) begin failures++; $display("FAIL b2b_wide j=%0d got=%h/%b%b%b/%0d exp=%h/%b%b%b/%0d", j, w_r, w_hs, w_vs, w_fs, w_fc, e.wr, e.wh, e.wv, e.wfs, e.wfc); end
      checks++; if ({n_r, o_r} !== {e.nr, e.orr}) begin failures++; $display("FAIL b2b_conv j=%0d got=%h/%h exp=%h/%h", j, n_r, o_r, e.nr, e.orr); end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_conversion();
    test_polarity();
    test_frames();
    test_midline_reset();
    test_pattern();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
